// File: rtl/picomips_pkg.sv
// Shared picoMIPS types and default constants for the operand-input stage.
package picomips_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      WAIT_PRESS   = 2'd1,
      WAIT_RELEASE = 2'd2,
      DONE         = 2'd3
   } sw_state_t;

   localparam int N_DEFAULT         = 8;
   localparam int DB_CYCLES_DEFAULT = 1_000_000;

endpackage

// File: rtl/btn_debounce.sv
// Push-button synchroniser and debouncer.
// With SW_INPUT_DEBOUNCE_EN defined the output flips only after DB_CYCLES steady clocks; otherwise it is the synced level registered once.
module btn_debounce
   import picomips_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic nreset,
   input  logic btn,
   output logic btn_stable
);

   // A window shorter than 2 would leave no room for the counter to filter anything.
   if (DB_CYCLES < 2) begin : g_bad_db_cycles
      $error("btn_debounce: DB_CYCLES must be >= 2");
   end

   logic [1:0] btn_sync;
   logic       btn_s;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         btn_sync <= 2'b00;
      end else begin
         btn_sync <= {btn_sync[0], btn};
      end
   end

   assign btn_s = btn_sync[1];

`ifdef SW_INPUT_DEBOUNCE_EN
   localparam int CW = $clog2(DB_CYCLES);

   logic [CW-1:0] cnt;

   // Any sample agreeing with the current stable level restarts the window.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         cnt        <= '0;
         btn_stable <= 1'b0;
      end else if (btn_s == btn_stable) begin
         cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
         cnt        <= '0;
         btn_stable <= ~btn_stable;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end
`else
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         btn_stable <= 1'b0;
      end else begin
         btn_stable <= btn_s;
      end
   end
`endif

endmodule

// File: rtl/sw_input_stage.sv
// picoMIPS operand-input stage: stalls the PC on an input instruction until a debounced press/release, then strobes the latched switches.
// Optional debounce counter is selected by SW_INPUT_DEBOUNCE_EN (see btn_debounce).
module sw_input_stage
   import picomips_pkg::*;
#(
   parameter int n         = N_DEFAULT,
   parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
   input  logic         clk,
   input  logic         nreset,
   input  logic [n-1:0] sw,
   input  logic         btn,
   input  logic         req,
   output logic [n-1:0] data,
   output logic         valid,
   output logic         stall,
   output sw_state_t    dbg_state
);

   logic [n-1:0] sw_meta;
   logic [n-1:0] sw_sync;
   logic         btn_stable;
   logic         btn_stable_q;
   logic         press;
   logic         btn_released;
   logic         capture;
   sw_state_t    state_q;
   sw_state_t    state_d;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         sw_meta <= '0;
         sw_sync <= '0;
      end else begin
         sw_meta <= sw;
         sw_sync <= sw_meta;
      end
   end

   btn_debounce #(
      .DB_CYCLES (DB_CYCLES)
   ) u_btn_debounce (
      .clk        (clk),
      .nreset     (nreset),
      .btn        (btn),
      .btn_stable (btn_stable)
   );

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         btn_stable_q <= 1'b0;
      end else begin
         btn_stable_q <= btn_stable;
      end
   end

   // Only a fresh rising edge counts, so a button already held when req rises is ignored.
   assign press        = btn_stable & ~btn_stable_q;
   assign btn_released = ~btn_stable;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) state_d = WAIT_PRESS;
         end
         WAIT_PRESS: begin
            if (press) begin
               capture = 1'b1;
               state_d = WAIT_RELEASE;
            end
         end
         WAIT_RELEASE: begin
            if (btn_released) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         data <= '0;
      end else if (capture) begin
         data <= sw_sync;
      end
   end

   // valid is a one-cycle strobe with no ready: the consumer takes data in the DONE
   // cycle, and stall (combinational on req in IDLE) holds the PC until then.
   always_comb begin
      stall = ((state_q == IDLE) && req) ||
              (state_q == WAIT_PRESS) ||
              (state_q == WAIT_RELEASE);
      valid = (state_q == DONE);
   end

   assign dbg_state = state_q;

endmodule

// File: tb/tb_sw_input_stage.sv
// Directed bench for sw_input_stage with DB_CYCLES=4; expected latencies follow the SW_INPUT_DEBOUNCE_EN build.
module tb_sw_input_stage;
   import picomips_pkg::*;

   localparam int DB = 4;
`ifdef SW_INPUT_DEBOUNCE_EN
   localparam int L = 2 + DB;
`else
   localparam int L = 3;
`endif

   typedef struct {
      logic [7:0] sw;
      logic [7:0] sw_late;
      logic [7:0] exp_data;
      int         hold;
   } vec_t;

   logic       clk;
   logic       nreset;
   logic [7:0] sw;
   logic       btn;
   logic       req;
   logic [7:0] data;
   logic       valid;
   logic       stall;
   sw_state_t  dbg_state;

   int         total;
   int         bad;
   logic [7:0] model_data;
   logic [7:0] exp_q[$];
   vec_t       vecs[5];

   sw_input_stage #(
      .n         (8),
      .DB_CYCLES (DB)
   ) dut (
      .clk       (clk),
      .nreset    (nreset),
      .sw        (sw),
      .btn       (btn),
      .req       (req),
      .data      (data),
      .valid     (valid),
      .stall     (stall),
      .dbg_state (dbg_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int cycles);
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Scoreboard: every valid strobe must match the oldest expected capture.
   always @(negedge clk) begin
      if (nreset && valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_valid", 32'(valid), 32'd0);
         end else begin
            check("sb_data", 32'(data), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic run_vector(input vec_t v);
      sw  = v.sw;
      req = 1'b1;
      #1;
      check("req_stall", 32'(stall), 32'd1);
      check("req_state", 32'(dbg_state), 32'(IDLE));
      tick(1);
      check("wp_state", 32'(dbg_state), 32'(WAIT_PRESS));
      btn = 1'b1;
      exp_q.push_back(v.exp_data);
      tick(L);
      check("pre_capture_data", 32'(data), 32'(model_data));
      check("pre_capture_stall", 32'(stall), 32'd1);
      tick(1);
      check("capture_data", 32'(data), 32'(v.exp_data));
      check("capture_state", 32'(dbg_state), 32'(WAIT_RELEASE));
      model_data = v.exp_data;
      sw = v.sw_late;
      tick(v.hold);
      btn = 1'b0;
      tick(L);
      check("pre_done_valid", 32'(valid), 32'd0);
      check("pre_done_stall", 32'(stall), 32'd1);
      check("held_data", 32'(data), 32'(model_data));
      tick(1);
      check("done_valid", 32'(valid), 32'd1);
      check("done_stall", 32'(stall), 32'd0);
      check("done_state", 32'(dbg_state), 32'(DONE));
      req = 1'b0;
      tick(1);
      check("post_valid", 32'(valid), 32'd0);
      check("post_state", 32'(dbg_state), 32'(IDLE));
      check("post_stall", 32'(stall), 32'd0);
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      model_data = 8'h00;
      vecs[0] = '{sw: 8'h5A, sw_late: 8'h00, exp_data: 8'h5A, hold: 3};
      vecs[1] = '{sw: 8'hFF, sw_late: 8'h12, exp_data: 8'hFF, hold: 1};
      vecs[2] = '{sw: 8'h00, sw_late: 8'hFF, exp_data: 8'h00, hold: 5};
      vecs[3] = '{sw: 8'hA5, sw_late: 8'h5A, exp_data: 8'hA5, hold: 2};
      vecs[4] = '{sw: 8'h81, sw_late: 8'h7E, exp_data: 8'h81, hold: 8};

      // Reset values, and stall follows req while reset is held.
      nreset = 1'b0;
      sw     = 8'h00;
      btn    = 1'b0;
      req    = 1'b0;
      #1;
      check("rst_data", 32'(data), 32'h00);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(IDLE));
      req = 1'b1;
      #1;
      check("rst_stall_req", 32'(stall), 32'd1);
      req = 1'b0;
      tick(3);
      nreset = 1'b1;
      tick(2);

      for (int i = 0; i < 5; i++) begin
         run_vector(vecs[i]);
      end

`ifdef SW_INPUT_DEBOUNCE_EN
      // Bounce shorter than the window: no capture until the level settles.
      sw  = 8'h3C;
      req = 1'b1;
      tick(1);
      for (int i = 0; i < 3; i++) begin
         btn = 1'b1;
         tick(2);
         btn = 1'b0;
         tick(2);
         check("bounce_state", 32'(dbg_state), 32'(WAIT_PRESS));
         check("bounce_data", 32'(data), 32'(model_data));
      end
      btn = 1'b1;
      exp_q.push_back(8'h3C);
      tick(L);
      check("bounce_pre_capture", 32'(data), 32'(model_data));
      tick(1);
      check("bounce_capture", 32'(data), 32'h3C);
      check("bounce_wr_state", 32'(dbg_state), 32'(WAIT_RELEASE));
      model_data = 8'h3C;
      tick(4);
      check("bounce_no_valid", 32'(valid), 32'd0);
      btn = 1'b0;
      tick(L + 1);
      check("bounce_valid", 32'(valid), 32'd1);
      req = 1'b0;
      tick(1);
      check("bounce_idle", 32'(dbg_state), 32'(IDLE));
`endif

      // Button already held when req rises, then switch change after press.
      btn = 1'b1;
      tick(L + 2);
      req = 1'b1;
      tick(3);
      check("preheld_state", 32'(dbg_state), 32'(WAIT_PRESS));
      check("preheld_data", 32'(data), 32'(model_data));
      check("preheld_stall", 32'(stall), 32'd1);
      btn = 1'b0;
      sw  = 8'h81;
      tick(L + 1);
      check("preheld_rel_state", 32'(dbg_state), 32'(WAIT_PRESS));
      btn = 1'b1;
      exp_q.push_back(8'h81);
      tick(L + 1);
      check("preheld_capture", 32'(data), 32'h81);
      sw = 8'hFF;
      tick(4);
      check("sw_change_ignored", 32'(data), 32'h81);
      model_data = 8'h81;
      btn = 1'b0;
      tick(L + 1);
      check("preheld_valid", 32'(valid), 32'd1);
      req = 1'b0;
      tick(1);

      // Reset in WAIT_RELEASE aborts with no valid.
      sw  = 8'hC3;
      req = 1'b1;
      tick(1);
      btn = 1'b1;
      tick(L + 2);
      check("abort_wr_state", 32'(dbg_state), 32'(WAIT_RELEASE));
      check("abort_wr_data", 32'(data), 32'hC3);
      nreset = 1'b0;
      #1;
      check("abort_state", 32'(dbg_state), 32'(IDLE));
      check("abort_data", 32'(data), 32'h00);
      check("abort_valid", 32'(valid), 32'd0);
      check("abort_stall_req", 32'(stall), 32'd1);
      req = 1'b0;
      btn = 1'b0;
      tick(2);
      nreset = 1'b1;
      tick(3 * L);
      check("abort_idle_after", 32'(dbg_state), 32'(IDLE));
      check("abort_data_after", 32'(data), 32'h00);
      check("abort_queue_left", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // The aborted capture never produces a strobe; drop its expectation at the reset.
   always @(negedge nreset) begin
      exp_q.delete();
   end

endmodule
